touch_read_scheduler: RTL and testbench

TOUCH_READ_SCHEDULER -- requirements
Module: touch_read_scheduler

---
 rtl/touch_read_scheduler.sv | 167 ++++++++++++++++
 tb/tb_touch_read_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/touch_read_scheduler.sv
// rtl/touch_read_scheduler.sv - interrupt-driven 4-byte touch coordinate fetch over an I2C read-command port
module touch_read_scheduler #(
    parameter logic [6:0] DEV_ADDR    = 7'h38,
    parameter logic [7:0] START_REG   = 8'h03,
    parameter int         TIMEOUT_CYC = 65535,
    parameter int         HOLDOFF_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_int_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_dev,
    output logic [7:0]  cmd_reg,
    output logic [2:0]  cmd_len,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_write_n,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, HOLDOFF} state_t;

    state_t      state, next_state;
    logic        sync1, sync2, int_edge;
    logic        pending;
    logic [31:0] cyc_cnt;
    logic [1:0]  byte_cnt;
    logic [3:0]  b0_lo, b2_lo;
    logic [7:0]  b1;
    logic [11:0] coord_x, coord_y;
    logic        new_data, timeout_err, irq_mask;
    logic        start_req, cnt_clr, byte_wr, last_byte, timeout_hit;
    logic        reg_wr, busy;
    logic        unused_wdata;

    assign cmd_dev      = DEV_ADDR;
    assign cmd_reg      = START_REG;
    assign cmd_len      = 3'd4;
    assign busy         = (state != IDLE);
    assign int_edge     = !sync1 && sync2;
    assign reg_wr       = avs_chipselect && !avs_write_n;
    assign irq          = new_data && irq_mask;
    assign unused_wdata = ^avs_writedata[31:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= in_int_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        cmd_valid   = 1'b0;
        start_req   = 1'b0;
        cnt_clr     = 1'b0;
        byte_wr     = 1'b0;
        last_byte   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (int_edge || pending) begin
                    next_state = REQ;
                    start_req  = 1'b1;
                end
            end
            REQ: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    next_state = WAIT_DATA;
                    cnt_clr    = 1'b1;
                end
            end
            WAIT_DATA: begin
                byte_wr   = rx_valid;
                last_byte = rx_valid && (byte_cnt == 2'd3);
                // A 4th byte landing on the final timeout cycle still completes the read
                if (last_byte) begin
                    next_state = HOLDOFF;
                    cnt_clr    = 1'b1;
                end else if (cyc_cnt == 32'(TIMEOUT_CYC - 1)) begin
                    next_state  = HOLDOFF;
                    cnt_clr     = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            HOLDOFF: begin
                if (cyc_cnt == 32'(HOLDOFF_CYC - 1)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= 1'b0;
            cyc_cnt  <= '0;
            byte_cnt <= '0;
            b0_lo    <= '0;
            b1       <= '0;
            b2_lo    <= '0;
            coord_x  <= '0;
            coord_y  <= '0;
        end else begin
            if (int_edge && busy) pending <= 1'b1;
            else if (start_req)   pending <= 1'b0;

            if (cnt_clr)                                    cyc_cnt <= '0;
            else if (state == WAIT_DATA || state == HOLDOFF) cyc_cnt <= cyc_cnt + 32'd1;

            if (cnt_clr && state == REQ) byte_cnt <= '0;
            else if (byte_wr)            byte_cnt <= byte_cnt + 2'd1;

            if (byte_wr) begin
                case (byte_cnt)
                    2'd0:    b0_lo <= rx_data[3:0];
                    2'd1:    b1    <= rx_data;
                    2'd2:    b2_lo <= rx_data[3:0];
                    default: ;
                endcase
            end
            if (last_byte) begin
                coord_x <= {b0_lo, b1};
                coord_y <= {b2_lo, rx_data};
            end
        end
    end

    // Flag sets take priority over a simultaneous clear write
    always_ff @(posedge clk) begin
        if (reset) begin
            new_data     <= 1'b0;
            timeout_err  <= 1'b0;
            irq_mask     <= 1'b0;
            avs_readdata <= '0;
        end else begin
            if (last_byte)                         new_data <= 1'b1;
            else if (reg_wr && avs_address == 2'd3) new_data <= 1'b0;

            if (timeout_hit)                       timeout_err <= 1'b1;
            else if (reg_wr && avs_address == 2'd3) timeout_err <= 1'b0;

            if (reg_wr && avs_address == 2'd2) irq_mask <= avs_writedata[0];

            case (avs_address)
                2'd0:    avs_readdata <= {4'b0, coord_x, 4'b0, coord_y};
                2'd1:    avs_readdata <= {29'b0, busy, timeout_err, new_data};
                2'd2:    avs_readdata <= {31'b0, irq_mask};
                default: avs_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_touch_read_scheduler.sv
// tb/tb_touch_read_scheduler.sv - directed self-checking bench for touch_read_scheduler
module tb_touch_read_scheduler;

    localparam int TO_CYC = 40;
    localparam int HO_CYC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_int_n;
    logic        cmd_valid, cmd_ready;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic [2:0]  cmd_len;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [1:0]  avs_address;
    logic        avs_chipselect, avs_write_n;
    logic [31:0] avs_writedata, avs_readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    touch_read_scheduler #(
        .DEV_ADDR(7'h38), .START_REG(8'h03), .TIMEOUT_CYC(TO_CYC), .HOLDOFF_CYC(HO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .in_int_n(in_int_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .avs_address(avs_address), .avs_chipselect(avs_chipselect),
        .avs_write_n(avs_write_n), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_chipselect = 1'b1; avs_write_n = 1'b1;
        step();
        d = avs_readdata;
        avs_chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        avs_address = a; avs_writedata = v; avs_chipselect = 1'b1; avs_write_n = 1'b0;
        step();
        avs_chipselect = 1'b0; avs_write_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic start_txn(input string tag);
        int n;
        n = 0;
        in_int_n = 1'b0;
        while (cmd_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " cmd_valid"}, {31'b0, cmd_valid}, 32'd1);
        chk({tag, " cmd_fields"}, {14'b0, cmd_dev, cmd_reg, cmd_len}, {14'b0, 7'h38, 8'h03, 3'd4});
        step();
        in_int_n = 1'b1;
        chk({tag, " cmd_drop"}, {31'b0, cmd_valid}, 32'd0);
    endtask

    task automatic wait_idle(input string tag, output int busy_polls);
        logic [31:0] d;
        busy_polls = 0;
        d = 32'h4;
        for (int i = 0; i < 200; i++) begin
            rd(2'd1, d);
            if (d[2] == 1'b0) break;
            busy_polls++;
        end
        chk({tag, " idle"}, {31'b0, d[2]}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int polls;
        int ncmd;

        reset = 1'b1; in_int_n = 1'b1; cmd_ready = 1'b1;
        rx_valid = 1'b0; rx_data = '0;
        avs_address = '0; avs_chipselect = 1'b0; avs_write_n = 1'b1; avs_writedata = '0;
        step(); step(); step();
        chk("rst cmd_valid", {31'b0, cmd_valid}, 32'd0);
        reset = 1'b0;
        rd(2'd0, d); chk("rst reg0", d, 32'd0);
        rd(2'd1, d); chk("rst reg1", d, 32'd0);
        rd(2'd2, d); chk("rst reg2", d, 32'd0);
        chk("rst irq", {31'b0, irq}, 32'd0);

        // Basic fetch with interrupt enabled
        wr(2'd2, 32'd1);
        rd(2'd2, d); chk("mask rd", d, 32'd1);
        start_txn("t1");
        rd(2'd1, d); chk("t1 busy", d, 32'd4);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h04); send_byte(8'h56);
        chk("t1 irq", {31'b0, irq}, 32'd1);
        rd(2'd0, d); chk("t1 reg0", d, 32'h0123_0456);
        rd(2'd1, d); chk("t1 reg1", d, 32'd5);
        rd(2'd3, d); chk("t1 reg3", d, 32'd0);
        wait_idle("t1", polls);
        wr(2'd3, 32'd0);
        rd(2'd1, d); chk("t1 clr", d, 32'd0);
        chk("t1 irq clr", {31'b0, irq}, 32'd0);

        // Timeout boundary and holdoff length
        start_txn("t2");
        repeat (TO_CYC - 2) step();
        rd(2'd1, d); chk("t2 pre_to", d, 32'd4);
        step();
        rd(2'd1, d); chk("t2 to", d, 32'd6);
        wait_idle("t2", polls);
        chk("t2 holdoff", polls, HO_CYC - 1);
        rd(2'd0, d); chk("t2 reg0 kept", d, 32'h0123_0456);
        rd(2'd1, d); chk("t2 reg1", d, 32'd2);
        wr(2'd3, 32'd0);

        // Two extra edges during WAIT_DATA collapse into one queued command
        start_txn("t3");
        repeat (3) step();
        in_int_n = 1'b0; repeat (3) step();
        in_int_n = 1'b1; repeat (3) step();
        in_int_n = 1'b0; repeat (3) step();
        in_int_n = 1'b1;
        send_byte(8'hFA); send_byte(8'hBC); send_byte(8'h07); send_byte(8'h89);
        ncmd = 0;
        for (int i = 0; i < 150; i++) begin
            if (cmd_valid && cmd_ready) ncmd++;
            step();
        end
        chk("t3 ncmd", ncmd, 32'd1);
        rd(2'd0, d); chk("t3 reg0", d, 32'h0ABC_0789);
        rd(2'd1, d); chk("t3 reg1", d, 32'd3);
        wr(2'd3, 32'd0);

        // Clear write colliding with the 4th byte
        start_txn("t4");
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rx_valid = 1'b1; rx_data = 8'h44;
        avs_address = 2'd3; avs_writedata = '0; avs_chipselect = 1'b1; avs_write_n = 1'b0;
        step();
        rx_valid = 1'b0; avs_chipselect = 1'b0; avs_write_n = 1'b1;
        rd(2'd1, d); chk("t4 reg1", d, 32'd5);
        rd(2'd0, d); chk("t4 reg0", d, 32'h0122_0344);
        wait_idle("t4", polls);

        // Reset in the middle of a burst
        start_txn("t5");
        send_byte(8'hAA); send_byte(8'hBB);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5 cmd_valid", {31'b0, cmd_valid}, 32'd0);
        rd(2'd1, d); chk("t5 reg1", d, 32'd0);
        rd(2'd0, d); chk("t5 reg0", d, 32'd0);
        send_byte(8'hCC); send_byte(8'hDD);
        rd(2'd0, d); chk("t5 reg0 post", d, 32'd0);
        rd(2'd1, d); chk("t5 reg1 post", d, 32'd0);
        rd(2'd2, d); chk("t5 mask", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
